eval_arbiter: RTL

Round-robin scheduler that shares one `evaluate_general` instance among `NUM_REQ` requesters (search workers). It latches a requester's board, side to move and attack populations, then holds them stable. It runs the evaluator's `board_valid` / `eval_valid` / `clear_eval` handshake and returns `eval_mg`, `eval_eg`, `material` and `insufficient_material` to the granted requester. A watchdog converts a stalled evaluation into an error response.

---
 rtl/eval_arbiter_pkg.sv | 21 ++
 rtl/eval_arbiter_if.sv | 66 ++++++
 rtl/eval_arbiter_rr_pick.sv | 38 +++
 rtl/eval_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/eval_arbiter_pkg.sv
// ============================================================================
//  Module  : eval_arbiter_pkg
//  Brief   : Board geometry and arbiter state encodings shared by eval_arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package eval_arbiter_pkg;

    localparam int PIECE_WIDTH = 4;
    localparam int BOARD_WIDTH = 64 * PIECE_WIDTH;

    localparam logic [2:0] EARB_IDLE      = 3'd0;
    localparam logic [2:0] EARB_ISSUE     = 3'd1;
    localparam logic [2:0] EARB_WAIT_EVAL = 3'd2;
    localparam logic [2:0] EARB_DRAIN     = 3'd3;
    localparam logic [2:0] EARB_RESPOND   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/eval_arbiter_if.sv
// ============================================================================
//  Module  : eval_arbiter_if
//  Brief   : Requester and evaluator bundle; slave = arbiter, master = users.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface eval_arbiter_if
    import eval_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int EVAL_WIDTH = 24
) ();

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*BOARD_WIDTH-1:0]  req_board;
    logic [NUM_REQ-1:0]              req_white_to_move;
    logic [NUM_REQ*6-1:0]            req_attack_white_pop;
    logic [NUM_REQ*6-1:0]            req_attack_black_pop;
    logic [NUM_REQ-1:0]              req_taken;

    logic [NUM_REQ-1:0]              resp_valid;
    logic [NUM_REQ-1:0]              resp_ack;
    logic signed [EVAL_WIDTH-1:0]    resp_eval_mg;
    logic signed [EVAL_WIDTH-1:0]    resp_eval_eg;
    logic signed [31:0]              resp_material;
    logic                            resp_insufficient;
    logic                            resp_error;

    logic [BOARD_WIDTH-1:0]          ev_board;
    logic                            ev_white_to_move;
    logic [5:0]                      ev_attack_white_pop;
    logic [5:0]                      ev_attack_black_pop;
    logic                            ev_board_valid;
    logic                            ev_clear_eval;
    logic                            ev_eval_valid;
    logic signed [EVAL_WIDTH-1:0]    ev_eval_mg;
    logic signed [EVAL_WIDTH-1:0]    ev_eval_eg;
    logic signed [31:0]              ev_material;
    logic                            ev_insufficient;

    logic                            busy;

    modport slave (
        input  req, req_board, req_white_to_move, req_attack_white_pop,
               req_attack_black_pop, resp_ack,
               ev_eval_valid, ev_eval_mg, ev_eval_eg, ev_material, ev_insufficient,
        output req_taken, resp_valid, resp_eval_mg, resp_eval_eg, resp_material,
               resp_insufficient, resp_error,
               ev_board, ev_white_to_move, ev_attack_white_pop, ev_attack_black_pop,
               ev_board_valid, ev_clear_eval, busy
    );

    modport master (
        output req, req_board, req_white_to_move, req_attack_white_pop,
               req_attack_black_pop, resp_ack,
               ev_eval_valid, ev_eval_mg, ev_eval_eg, ev_material, ev_insufficient,
        input  req_taken, resp_valid, resp_eval_mg, resp_eval_eg, resp_material,
               resp_insufficient, resp_error,
               ev_board, ev_white_to_move, ev_attack_white_pop, ev_attack_black_pop,
               ev_board_valid, ev_clear_eval, busy
    );

endinterface

`default_nettype wire

// File: rtl/eval_arbiter_rr_pick.sv
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin picker, scans from last_grant+1 with wrap.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    always_comb begin
        int w_idx;
        w_idx       = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        // Offset N wraps back onto last_grant itself, so it only wins when alone.
        for (int off = 1; off <= N; off++) begin
            w_idx = (int'(i_last_grant) + off) % N;
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/eval_arbiter.sv
// ============================================================================
//  Module  : eval_arbiter
//  Brief   : Round-robin share of one evaluator with held inputs and watchdog.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module eval_arbiter
    import eval_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int EVAL_WIDTH = 24,
    parameter int TIMEOUT    = 31
) (
    input  logic          clk,
    input  logic          reset_n,
    eval_arbiter_if.slave bus
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);

    logic [2:0]                   r_state, w_next_state;
    logic [NUM_REQ-1:0]           r_grant, w_pick_grant;
    logic [c_IDX_W-1:0]           r_grant_idx, r_last_grant, w_pick_idx;
    logic                         w_pick_any;
    logic [c_WD_W-1:0]            r_wd;
    logic                         r_drain_seen;
    logic                         w_wd_expired;
    logic                         w_latch, w_capture, w_timeout, w_ack;

    logic [NUM_REQ-1:0]           r_req_taken, r_resp_valid;
    logic signed [EVAL_WIDTH-1:0] r_resp_mg, r_resp_eg;
    logic signed [31:0]           r_resp_material;
    logic                         r_resp_insufficient, r_resp_error;
    logic [BOARD_WIDTH-1:0]       r_ev_board;
    logic                         r_ev_white_to_move;
    logic [5:0]                   r_ev_attack_white_pop, r_ev_attack_black_pop;
    logic                         r_ev_board_valid, r_ev_clear_eval, r_busy;

    rr_pick #(.N(NUM_REQ), .IDX_W(c_IDX_W)) u_rr_pick (
        .i_req        (bus.req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_grant_idx  (w_pick_idx),
        .o_any        (w_pick_any)
    );

    assign w_wd_expired = (r_wd == c_WD_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= EARB_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EARB_IDLE:      if (w_pick_any) w_next_state = EARB_ISSUE;
            EARB_ISSUE:     w_next_state = EARB_WAIT_EVAL;
            EARB_WAIT_EVAL: if (bus.ev_eval_valid || w_wd_expired) w_next_state = EARB_DRAIN;
            EARB_DRAIN:     if (r_drain_seen && !bus.ev_eval_valid) w_next_state = EARB_RESPOND;
            EARB_RESPOND:   if (bus.resp_ack[r_grant_idx]) w_next_state = EARB_IDLE;
            default:        w_next_state = EARB_IDLE;
        endcase
    end

    always_comb begin
        w_latch   = (r_state == EARB_IDLE) && w_pick_any;
        w_capture = (r_state == EARB_WAIT_EVAL) && bus.ev_eval_valid;
        w_timeout = (r_state == EARB_WAIT_EVAL) && !bus.ev_eval_valid && w_wd_expired;
        w_ack     = (r_state == EARB_RESPOND) && bus.resp_ack[r_grant_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grant               <= '0;
            r_grant_idx           <= '0;
            r_last_grant          <= c_IDX_W'(NUM_REQ - 1);
            r_wd                  <= '0;
            r_drain_seen          <= 1'b0;
            r_req_taken           <= '0;
            r_resp_valid          <= '0;
            r_resp_mg             <= '0;
            r_resp_eg             <= '0;
            r_resp_material       <= '0;
            r_resp_insufficient   <= 1'b0;
            r_resp_error          <= 1'b0;
            r_ev_board            <= '0;
            r_ev_white_to_move    <= 1'b0;
            r_ev_attack_white_pop <= '0;
            r_ev_attack_black_pop <= '0;
            r_ev_board_valid      <= 1'b0;
            r_ev_clear_eval       <= 1'b0;
            r_busy                <= 1'b0;
        end else begin
            r_req_taken      <= w_latch ? w_pick_grant : '0;
            r_ev_board_valid <= w_latch;
            r_ev_clear_eval  <= w_capture || w_timeout;
            r_busy           <= (w_next_state != EARB_IDLE);
            r_resp_valid     <= (w_next_state == EARB_RESPOND) ? r_grant : '0;

            // Hold registers only move on a new grant; the evaluator resamples them every cycle.
            if (w_latch) begin
                r_grant               <= w_pick_grant;
                r_grant_idx           <= w_pick_idx;
                r_ev_board            <= bus.req_board[int'(w_pick_idx)*BOARD_WIDTH +: BOARD_WIDTH];
                r_ev_white_to_move    <= bus.req_white_to_move[w_pick_idx];
                r_ev_attack_white_pop <= bus.req_attack_white_pop[int'(w_pick_idx)*6 +: 6];
                r_ev_attack_black_pop <= bus.req_attack_black_pop[int'(w_pick_idx)*6 +: 6];
            end

            if (r_state == EARB_ISSUE)
                r_wd <= '0;
            else if ((r_state == EARB_WAIT_EVAL) && !w_wd_expired)
                r_wd <= r_wd + 1'b1;

            if (w_capture || w_timeout)    r_drain_seen <= 1'b0;
            else if (r_state == EARB_DRAIN) r_drain_seen <= 1'b1;

            if (w_capture) begin
                r_resp_mg           <= bus.ev_eval_mg;
                r_resp_eg           <= bus.ev_eval_eg;
                r_resp_material     <= bus.ev_material;
                r_resp_insufficient <= bus.ev_insufficient;
                r_resp_error        <= 1'b0;
            end else if (w_timeout) begin
                r_resp_mg           <= '0;
                r_resp_eg           <= '0;
                r_resp_material     <= '0;
                r_resp_insufficient <= 1'b0;
                r_resp_error        <= 1'b1;
            end

            if (w_ack) r_last_grant <= r_grant_idx;
        end
    end

    assign bus.req_taken           = r_req_taken;
    assign bus.resp_valid          = r_resp_valid;
    assign bus.resp_eval_mg        = r_resp_mg;
    assign bus.resp_eval_eg        = r_resp_eg;
    assign bus.resp_material       = r_resp_material;
    assign bus.resp_insufficient   = r_resp_insufficient;
    assign bus.resp_error          = r_resp_error;
    assign bus.ev_board            = r_ev_board;
    assign bus.ev_white_to_move    = r_ev_white_to_move;
    assign bus.ev_attack_white_pop = r_ev_attack_white_pop;
    assign bus.ev_attack_black_pop = r_ev_attack_black_pop;
    assign bus.ev_board_valid      = r_ev_board_valid;
    assign bus.ev_clear_eval       = r_ev_clear_eval;
    assign bus.busy                = r_busy;

endmodule

`default_nettype wire
